mtr_drv_pwm: RTL and testbench
==============================

// Module: mtr_drv_pwm
// PURPOSE
//  Consumes the signed 12-bit lft_spd/rght_spd commands from the balance-math stage and drives both motor H-bridges.
//  Converts each speed to an 11-bit duty, generates complementary high/low PWM pairs with non-overlap dead time,
//  and latches new duties only at period boundaries. Contains a period-sampled over-current monitor with sticky fault shutdown.
//  Sits between the balance-math output and the pad-level motor driver pins.
// PARAMETERS
//  NONOVERLAP  11'h020  dead-time cycles between PWM1 and PWM2 of one bridge
//  OVR_LIMIT   4'd5     consecutive periods with ovr_I sampled high that trip fault
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  en         in   1   drive enable (asynchronous domain; 2-flop synced internally)
//  lft_spd    in   12  signed left speed command
//  rght_spd   in   12  signed right speed command
//  ovr_I      in   1   over-current flag from bridge (asynchronous; 2-flop synced internally)
//  lft_PWM1   out  1   left high-side drive
//  lft_PWM2   out  1   left low-side drive
//  rght_PWM1  out  1   right high-side drive
//  rght_PWM2  out  1   right low-side drive
//  PWM_synch  out  1   one-cycle pulse at each period boundary
//  fault      out  1   sticky over-current shutdown indicator
// BEHAVIOUR
//  Reset: all outputs 0; cnt=0; duty shadows=11'h400; state=OFF; ovr_cnt=0. Clock and reset are as fixed above.
//  cnt: 11-bit free-running, increments every clk in all states, wraps 2047->0. Period = 2048 clk.
//  Duty: duty = sat(spd + 1024) to [0,2047]. Compute the sum at 13-bit signed width.
//   Examples: 12'h800 -> 0, 12'h000 -> 1024, 12'h7FF -> 2047.
//  Shadow update: on the clk where cnt==2047, lft/rght duty shadows load the current sat duty.
//   Mid-period spd changes have no effect until the next period.
//  PWM_synch: registered, high exactly one cycle following the cnt==2047 cycle, i.e. while cnt==0.
//  Compare (per bridge, 12-bit unsigned): p1 = (cnt>=NONOVERLAP)&&(cnt<duty_sh); p2 = (cnt>=duty_sh+NONOVERLAP).
//   Outputs are registered: PWMx reflects the compare on the previous cnt value (1-cycle lag, uniform for all four).
//   p1 and p2 are never both high. Each transition has >=NONOVERLAP cycles with both low.
//  Pulse widths: PWM1 high max(0,duty-NONOVERLAP) cycles; PWM2 high max(0,2048-duty-NONOVERLAP) cycles.
//  State machine (2-bit): OFF, RUN, FAULT.
//   OFF: all PWM outputs forced 0. Moves to RUN at the cnt==2047 edge when en_sync=1, so it starts on a clean period.
//   RUN: outputs follow compare. If en_sync=0, moves to OFF on the next clk; outputs 0 in the cycle after.
//   FAULT: all PWM outputs 0; fault=1. Sticky; only rst exits. en is ignored.
//  Over-current: in RUN only, ovr_sync is sampled once per period at cnt==2047.
//   Sample high: ovr_cnt++ (saturating). Sample low: ovr_cnt=0. ovr_cnt is cleared on entry to OFF.
//   When the sample makes ovr_cnt==OVR_LIMIT, the next state is FAULT. PWM outputs are 0 from the next clk, and fault rises in the same cycle.
//  Simultaneous events: in the same cnt==2047 cycle, FAULT trip wins over en deassert, and en deassert wins over the shadow update (the shadow still loads).
//  rst mid-period or mid-FAULT: immediate asynchronous clear to reset values; a new period starts at cnt=0.
//  PWM_synch and the duty shadows keep operating in OFF and FAULT.
// TESTING
//  1 en=1, lft_spd=0, NONOVERLAP=32 -> lft_PWM1 high 992 cycles and lft_PWM2 high 992 cycles per 2048; two 32-cycle both-low gaps.
//  2 lft_spd=12'h7FF -> PWM1 high 2015 cycles, PWM2 never high. lft_spd=12'h800 -> PWM1 never high, PWM2 high 2016 cycles.
//    Also check rght_spd independently at the same time.
//  3 lft_spd 0->12'h200 at cnt==500 -> current period widths unchanged; next period PWM1 high 1504 cycles. PWM_synch width is 1 cycle.
//  4 ovr_I held high across 5 boundaries -> fault=1 and all PWM=0 after the 5th sample.
//    Pattern 4 high, 1 low, 4 high -> no fault.
//  5 en dropped at cnt==300 in RUN -> all PWM 0 within 3 clk (sync+1). Re-assert -> PWM resumes at the next cnt==0, never mid-period.
//  6 rst pulsed while in FAULT and mid-period -> all outputs 0 immediately, fault=0, cnt=0, duty shadows=0x400.
//    With en=1 held, RUN resumes at the first boundary.

Source files
------------

// File: rtl/mtr_drv_pwm.sv
// mtr_drv_pwm: converts signed left/right speed commands into complementary
// high/low PWM pairs for two H-bridges. Duties are held in shadow registers
// that reload only at the end of each 2048-cycle period. A per-period
// over-current sampler trips a sticky FAULT state that only rst clears.
// dbg_state_o exposes the control FSM state (0=OFF, 1=RUN, 2=FAULT).
module mtr_drv_pwm #(
  parameter logic [10:0] NONOVERLAP = 11'h020,
  parameter logic [3:0]  OVR_LIMIT  = 4'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        ovr_I,
  output logic        lft_PWM1,
  output logic        lft_PWM2,
  output logic        rght_PWM1,
  output logic        rght_PWM2,
  output logic        PWM_synch,
  output logic        fault,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [10:0] CNT_LAST = 11'h7FF;

  // Synchronizer flops for the two asynchronous inputs
  logic en_meta_q, en_sync_q;
  logic ovr_meta_q, ovr_sync_q;

  // Period counter and duty shadows
  logic [10:0] cnt_q;
  logic [10:0] lft_duty_q, rght_duty_q;
  logic [10:0] lft_duty_d, rght_duty_d;

  // Control FSM and over-current counter
  state_e     state_q, state_d;
  logic [3:0] ovr_cnt_q, ovr_cnt_d;

  // Registered outputs
  logic lft_p1_q, lft_p2_q, rght_p1_q, rght_p2_q;
  logic lft_p1_d, lft_p2_d, rght_p1_d, rght_p2_d;
  logic synch_q, fault_q;
  logic synch_d, fault_d;

  // Combinational helpers
  logic period_end;
  logic drive_en;
  logic lft_cmp1, lft_cmp2, rght_cmp1, rght_cmp2;

  // Saturate spd + 1024 (computed 13-bit signed) into the 11-bit duty range.
  function automatic logic [10:0] sat_duty(input logic [11:0] spd);
    logic [12:0] sum;
    sum = {spd[11], spd} + 13'h0400;
    if (sum[12]) begin
      sat_duty = 11'h000;          // negative sum clamps to 0
    end else if (sum[11]) begin
      sat_duty = 11'h7FF;          // sum >= 2048 clamps to 2047
    end else begin
      sat_duty = sum[10:0];
    end
  endfunction

  // High side on from NONOVERLAP up to duty; low side on from duty+NONOVERLAP.
  // Both compares are done at 12 bits so duty+NONOVERLAP cannot wrap.
  function automatic logic cmp_hi(input logic [10:0] cnt, input logic [10:0] duty);
    cmp_hi = ({1'b0, cnt} >= {1'b0, NONOVERLAP}) && ({1'b0, cnt} < {1'b0, duty});
  endfunction

  function automatic logic cmp_lo(input logic [10:0] cnt, input logic [10:0] duty);
    cmp_lo = {1'b0, cnt} >= ({1'b0, duty} + {1'b0, NONOVERLAP});
  endfunction

  // Two-flop synchronizers for en and ovr_I
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_meta_q  <= 1'b0;
      en_sync_q  <= 1'b0;
      ovr_meta_q <= 1'b0;
      ovr_sync_q <= 1'b0;
    end else begin
      en_meta_q  <= en;
      en_sync_q  <= en_meta_q;
      ovr_meta_q <= ovr_I;
      ovr_sync_q <= ovr_meta_q;
    end
  end

  // Free-running period counter, wraps 2047 -> 0 in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 11'h000;
    end else begin
      cnt_q <= cnt_q + 11'h001;
    end
  end

  // Saturated duty of the live commands and shadow-load selection
  always_comb begin
    period_end  = (cnt_q == CNT_LAST);
    lft_duty_d  = lft_duty_q;
    rght_duty_d = rght_duty_q;
    if (period_end) begin
      lft_duty_d  = sat_duty(lft_spd);
      rght_duty_d = sat_duty(rght_spd);
    end
  end

  // Duty shadows reload only at the period boundary, in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_duty_q  <= 11'h400;
      rght_duty_q <= 11'h400;
    end else begin
      lft_duty_q  <= lft_duty_d;
      rght_duty_q <= rght_duty_d;
    end
  end

  // FSM state and over-current counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      ovr_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  // Next-state logic: fault trip beats en deassert at a boundary
  always_comb begin
    state_d   = state_q;
    ovr_cnt_d = ovr_cnt_q;
    unique case (state_q)
      ST_OFF: begin
        ovr_cnt_d = 4'd0;
        if (period_end && en_sync_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (period_end) begin
          if (ovr_sync_q) begin
            if (ovr_cnt_q != 4'hF) begin
              ovr_cnt_d = ovr_cnt_q + 4'd1;
            end
          end else begin
            ovr_cnt_d = 4'd0;
          end
        end
        if (period_end && ovr_sync_q && (ovr_cnt_d == OVR_LIMIT)) begin
          state_d = ST_FAULT;
        end else if (!en_sync_q) begin
          state_d   = ST_OFF;
          ovr_cnt_d = 4'd0;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d   = ST_OFF;
        ovr_cnt_d = 4'd0;
      end
    endcase
  end

  // Output compare; bridges only drive while the FSM stays in RUN
  always_comb begin
    lft_cmp1  = cmp_hi(cnt_q, lft_duty_q);
    lft_cmp2  = cmp_lo(cnt_q, lft_duty_q);
    rght_cmp1 = cmp_hi(cnt_q, rght_duty_q);
    rght_cmp2 = cmp_lo(cnt_q, rght_duty_q);
    drive_en  = (state_q == ST_RUN) && (state_d == ST_RUN);
    lft_p1_d  = drive_en && lft_cmp1;
    lft_p2_d  = drive_en && lft_cmp2;
    rght_p1_d = drive_en && rght_cmp1;
    rght_p2_d = drive_en && rght_cmp2;
    synch_d   = period_end;
    fault_d   = (state_d == ST_FAULT);
  end

  // Registered PWM, synch and fault outputs (uniform one-cycle lag)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_p1_q  <= 1'b0;
      lft_p2_q  <= 1'b0;
      rght_p1_q <= 1'b0;
      rght_p2_q <= 1'b0;
      synch_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      lft_p1_q  <= lft_p1_d;
      lft_p2_q  <= lft_p2_d;
      rght_p1_q <= rght_p1_d;
      rght_p2_q <= rght_p2_d;
      synch_q   <= synch_d;
      fault_q   <= fault_d;
    end
  end

  assign lft_PWM1    = lft_p1_q;
  assign lft_PWM2    = lft_p2_q;
  assign rght_PWM1   = rght_p1_q;
  assign rght_PWM2   = rght_p2_q;
  assign PWM_synch   = synch_q;
  assign fault       = fault_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Bench for mtr_drv_pwm: measures per-period high times of all four PWM
// outputs and compares them against widths derived from a duty model.
module tb_mtr_drv_pwm;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        ovr_I;
  logic        lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2;
  logic        PWM_synch;
  logic        fault;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];

  // Results of the most recent measurement window
  logic [11:0] w_l1, w_l2, w_r1, w_r2, w_bl;
  int          w_ovl, w_syn;
  logic        w_last_syn;

  mtr_drv_pwm dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .lft_spd     (lft_spd),
    .rght_spd    (rght_spd),
    .ovr_I       (ovr_I),
    .lft_PWM1    (lft_PWM1),
    .lft_PWM2    (lft_PWM2),
    .rght_PWM1   (rght_PWM1),
    .rght_PWM2   (rght_PWM2),
    .PWM_synch   (PWM_synch),
    .fault       (fault),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic int duty_of(input logic [11:0] s);
    int v;
    v = $signed(s) + 1024;
    if (v < 0) v = 0;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  function automatic int hi_width(input int d);
    return (d > 32) ? d - 32 : 0;
  endfunction

  function automatic int lo_width(input int d);
    return ((2048 - d) > 32) ? 2048 - d - 32 : 0;
  endfunction

  // Scoreboard push: l1, l2, r1, r2, left both-low count
  task automatic push_exp(input logic [11:0] ls, input logic [11:0] rs, input bit running);
    int dl, dr, l1, l2, r1, r2;
    dl = duty_of(ls);
    dr = duty_of(rs);
    l1 = running ? hi_width(dl) : 0;
    l2 = running ? lo_width(dl) : 0;
    r1 = running ? hi_width(dr) : 0;
    r2 = running ? lo_width(dr) : 0;
    exp_q.push_back(12'(l1));
    exp_q.push_back(12'(l2));
    exp_q.push_back(12'(r1));
    exp_q.push_back(12'(r2));
    exp_q.push_back(12'(2048 - l1 - l2));
  endtask

  // Driver: wait (bounded) for the next PWM_synch pulse
  task automatic wait_synch(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (PWM_synch !== 1'b1 && n < 4200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (PWM_synch !== 1'b1) begin
      errors++;
      $display("FAIL %s_synch_timeout: observed %b expected 1", tag, PWM_synch);
    end
  endtask

  // Sample one full period starting right after a synch negedge (cnt==0).
  // Optionally changes lft_spd after sample index chg_at (cnt == chg_at+1).
  task automatic measure_window(input int chg_at, input logic [11:0] chg_val);
    int l1, l2, r1, r2, bl;
    l1 = 0; l2 = 0; r1 = 0; r2 = 0; bl = 0;
    w_ovl = 0; w_syn = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (lft_PWM1 === 1'b1) l1++;
      if (lft_PWM2 === 1'b1) l2++;
      if (rght_PWM1 === 1'b1) r1++;
      if (rght_PWM2 === 1'b1) r2++;
      if (lft_PWM1 === 1'b0 && lft_PWM2 === 1'b0) bl++;
      if ((lft_PWM1 && lft_PWM2) || (rght_PWM1 && rght_PWM2)) w_ovl++;
      if (PWM_synch === 1'b1) w_syn++;
      if (i == chg_at) lft_spd = chg_val;
    end
    w_last_syn = PWM_synch;
    w_l1 = 12'(l1); w_l2 = 12'(l2); w_r1 = 12'(r1); w_r2 = 12'(r2); w_bl = 12'(bl);
  endtask

  // Scoreboard pop/compare for one measured window
  task automatic check_widths(input string tag);
    logic [11:0] obs [5];
    string       nm  [5];
    logic [11:0] e;
    obs = '{w_l1, w_l2, w_r1, w_r2, w_bl};
    nm  = '{"lft_PWM1_width", "lft_PWM2_width", "rght_PWM1_width", "rght_PWM2_width", "lft_both_low"};
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_%s: observed %0d expected <queue empty>", tag, nm[k], obs[k]);
      end else begin
        e = exp_q.pop_front();
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL %s_%s: observed %0d expected %0d", tag, nm[k], obs[k], e);
        end
      end
    end
    checks++;
    if (w_ovl !== 0) begin
      errors++;
      $display("FAIL %s_overlap: observed %0d expected 0", tag, w_ovl);
    end
    checks++;
    if (w_syn !== 1 || w_last_syn !== 1'b1) begin
      errors++;
      $display("FAIL %s_synch_width: observed %0d pulses (last %b) expected 1 (last 1)", tag, w_syn, w_last_syn);
    end
  endtask

  // Count cycles from rst release to the first synch; expect exactly 2048
  task automatic check_period_start(input string tag);
    int n, hi;
    n = 0; hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (n < 2048 && (lft_PWM1 || lft_PWM2 || rght_PWM1 || rght_PWM2)) hi++;
    end while (PWM_synch !== 1'b1 && n < 5000);
    checks++;
    if (n !== 2048) begin
      errors++;
      $display("FAIL %s_first_synch: observed %0d cycles expected 2048", tag, n);
    end
    checks++;
    if (hi !== 0) begin
      errors++;
      $display("FAIL %s_off_pwm: observed %0d high cycles expected 0", tag, hi);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ovr_I = 1'b0; lft_spd = 12'h000; rght_spd = 12'h000;
    repeat (3) @(negedge clk);
    checks++;
    if ({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, fault} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: observed %b expected 000000",
               {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, fault});
    end
    checks++;
    if (dbg_state_o !== S_OFF) begin
      errors++;
      $display("FAIL reset_state: observed %0d expected %0d", dbg_state_o, S_OFF);
    end
    @(negedge clk);
    rst = 1'b0;
    check_period_start("reset");
  endtask

  task automatic test_basic();
    en = 1'b1; lft_spd = 12'h000; rght_spd = 12'h100;
    push_exp(lft_spd, rght_spd, 1'b1);
    wait_synch("basic");
    measure_window(-1, 12'h000);
    check_widths("basic");
  endtask

  task automatic test_extremes();
    logic [11:0] tl [3];
    logic [11:0] tr [3];
    tl = '{12'h7FF, 12'h800, 12'h000};
    tr = '{12'h800, 12'h7FF, 12'h000};
    tl[2] = 12'($urandom_range(0, 4095));
    tr[2] = 12'($urandom_range(0, 4095));
    for (int k = 0; k < 3; k++) begin
      lft_spd = tl[k]; rght_spd = tr[k];
      push_exp(tl[k], tr[k], 1'b1);
      wait_synch("extremes");
      measure_window(-1, 12'h000);
      check_widths($sformatf("extremes%0d", k));
    end
  endtask

  task automatic test_midperiod();
    lft_spd = 12'h000; rght_spd = 12'h000;
    wait_synch("mid");
    push_exp(12'h000, 12'h000, 1'b1);
    measure_window(499, 12'h200);
    check_widths("mid_current");
    push_exp(12'h200, 12'h000, 1'b1);
    measure_window(-1, 12'h200);
    check_widths("mid_next");
  endtask

  task automatic test_en_drop();
    int hi;
    lft_spd = 12'h000; rght_spd = 12'h000;
    wait_synch("en");
    repeat (300) @(negedge clk);
    checks++;
    if (lft_PWM1 !== 1'b1) begin
      errors++;
      $display("FAIL en_active_before_drop: observed %b expected 1", lft_PWM1);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2} !== 4'b0 || dbg_state_o !== S_OFF) begin
      errors++;
      $display("FAIL en_drop_off: observed pwm %b state %0d expected pwm 0000 state %0d",
               {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}, dbg_state_o, S_OFF);
    end
    wait_synch("en_off");
    push_exp(lft_spd, rght_spd, 1'b0);
    measure_window(-1, 12'h000);
    check_widths("en_off");
    repeat (1000) @(negedge clk);
    en = 1'b1;
    hi = 0;
    for (int n = 0; n < 4200; n++) begin
      @(negedge clk);
      if (lft_PWM1 || lft_PWM2 || rght_PWM1 || rght_PWM2) hi++;
      if (PWM_synch === 1'b1) break;
    end
    checks++;
    if (hi !== 0 || PWM_synch !== 1'b1) begin
      errors++;
      $display("FAIL en_resume_midperiod: observed %0d high cycles synch %b expected 0 and 1", hi, PWM_synch);
    end
    checks++;
    if (dbg_state_o !== S_RUN) begin
      errors++;
      $display("FAIL en_resume_state: observed %0d expected %0d", dbg_state_o, S_RUN);
    end
    push_exp(lft_spd, rght_spd, 1'b1);
    measure_window(-1, 12'h000);
    check_widths("en_resume");
  endtask

  task automatic test_overcurrent();
    bit pat [9];
    int hi;
    pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    wait_synch("ovr");
    for (int k = 0; k < 9; k++) begin
      ovr_I = pat[k];
      wait_synch("ovr_pat");
      checks++;
      if (fault !== 1'b0) begin
        errors++;
        $display("FAIL ovr_pattern_%0d: observed fault %b expected 0", k, fault);
      end
    end
    ovr_I = 1'b0;
    wait_synch("ovr_clear");
    for (int k = 1; k <= 5; k++) begin
      ovr_I = 1'b1;
      wait_synch("ovr_trip");
      checks++;
      if (fault !== (k == 5)) begin
        errors++;
        $display("FAIL ovr_trip_%0d: observed fault %b expected %b", k, fault, (k == 5));
      end
    end
    checks++;
    if ({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2} !== 4'b0 || dbg_state_o !== S_FAULT) begin
      errors++;
      $display("FAIL ovr_fault_outputs: observed pwm %b state %0d expected pwm 0000 state %0d",
               {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2}, dbg_state_o, S_FAULT);
    end
    ovr_I = 1'b0;
    hi = 0;
    for (int n = 0; n < 2100; n++) begin
      @(negedge clk);
      en = (n < 1000) ? 1'b0 : 1'b1;
      if (lft_PWM1 || lft_PWM2 || rght_PWM1 || rght_PWM2) hi++;
    end
    checks++;
    if (hi !== 0 || fault !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky: observed %0d high cycles fault %b expected 0 and 1", hi, fault);
    end
  endtask

  task automatic test_reset_in_fault();
    en = 1'b1; ovr_I = 1'b0; lft_spd = 12'h000; rght_spd = 12'h100;
    wait_synch("rstf");
    repeat (700) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, fault} !== 6'b0 || dbg_state_o !== S_OFF) begin
      errors++;
      $display("FAIL rstf_immediate: observed %b state %0d expected 000000 state %0d",
               {lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, fault}, dbg_state_o, S_OFF);
    end
    @(negedge clk);
    rst = 1'b0;
    check_period_start("rstf");
    push_exp(lft_spd, rght_spd, 1'b1);
    measure_window(-1, 12'h000);
    check_widths("rstf_resume");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_midperiod();
    test_en_drop();
    test_overcurrent();
    test_reset_in_fault();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
